// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module     : instr_fetch_unit_if
//  Description: Bundle of the fetch-control, redirect, instruction-memory and
//               decoded-instruction signals of instr_fetch_unit.
//               slave  modport : the fetch unit itself
//               master modport : whoever drives the fetch unit (control unit,
//                                EX redirect, instruction memory)
//  Signals    : enIF, pc_load, pc_target[7:0], imem_rdata[15:0], imem_ack
//               (into the fetch unit); imem_req, imem_addr[7:0], opCode[3:0],
//               rd/rs/rt[2:0], imm6[5:0], pc[7:0], ir_valid, fetch_done,
//               fetch_err, overrun (out of the fetch unit)
//  Revision   : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        enIF;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [3:0]  opCode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [5:0]  imm6;
    logic [7:0]  pc;
    logic        ir_valid;
    logic        fetch_done;
    logic        fetch_err;
    logic        overrun;

    modport slave (
        input  enIF, pc_load, pc_target, imem_rdata, imem_ack,
        output imem_req, imem_addr, opCode, rd, rs, rt, imm6, pc,
               ir_valid, fetch_done, fetch_err, overrun
    );

    modport master (
        output enIF, pc_load, pc_target, imem_rdata, imem_ack,
        input  imem_req, imem_addr, opCode, rd, rs, rt, imm6, pc,
               ir_valid, fetch_done, fetch_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : instr_fetch_unit
//  Description: Single-outstanding instruction fetch unit. On an enIF strobe
//               in IDLE it issues one read of the current PC, waits for
//               imem_ack (up to 15 cycles), captures the word into the IR,
//               advances the PC and pulses fetch_done. A timeout raises the
//               sticky fetch_err; enIF while busy raises the sticky overrun.
//               pc_load redirects the PC in any state and wins over the
//               post-fetch increment.
//  Ports      : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - instr_fetch_unit_if.slave (control, redirect,
//                       instruction memory and decoded-IR signals)
//  Revision   : 1.0  initial release
// ============================================================================
module instr_fetch_unit (
    input  wire logic                clk,
    input  wire logic                reset,
    instr_fetch_unit_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last wait-counter value at which a missing ack is still tolerated;
    // the next ack-less REQ cycle would bring the counter to 15 -> timeout.
    localparam logic [3:0] c_WAIT_LAST = 4'd14;

    state_t      state_q,     state_d;
    logic [7:0]  pc_q,        pc_d;
    logic [7:0]  addr_q,      addr_d;
    logic [15:0] ir_q,        ir_d;
    logic        ir_valid_q,  ir_valid_d;
    logic [3:0]  wait_q,      wait_d;
    logic        fetch_err_q, fetch_err_d;
    logic        overrun_q,   overrun_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= 8'h00;
            addr_q      <= 8'h00;
            ir_q        <= 16'h0000;
            ir_valid_q  <= 1'b0;
            wait_q      <= 4'd0;
            fetch_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        wait_d      = wait_q;
        fetch_err_d = fetch_err_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                // imem_ack here is stale or spurious and is deliberately ignored.
                if (bus.enIF) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                    wait_d  = 4'd0;
                end
            end

            REQ: begin
                // addr_q is not touched here, so a redirect cannot disturb
                // the address of the read already in flight.
                if (bus.imem_ack) begin
                    ir_d       = bus.imem_rdata;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 8'd1;   // wraps 0xFF -> 0x00 silently
                    state_d    = DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if (wait_q == c_WAIT_LAST) begin
                        fetch_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                if (bus.enIF) begin
                    overrun_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                if (bus.enIF) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides any increment computed above.
        if (bus.pc_load) begin
            pc_d = bus.pc_target;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_req   = (state_q == REQ);
    assign bus.fetch_done = (state_q == DONE);
    assign bus.imem_addr  = addr_q;
    assign bus.pc         = pc_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.overrun    = overrun_q;

    // Instruction field decode: IR = opCode[15:12] rd[11:9] rs[8:6] rt[5:3];
    // imm6 overlaps rt and the low three bits.
    assign bus.opCode = ir_q[15:12];
    assign bus.rd     = ir_q[11:9];
    assign bus.rs     = ir_q[8:6];
    assign bus.rt     = ir_q[5:3];
    assign bus.imm6   = ir_q[5:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : tb_instr_fetch_unit
//  Description: Directed self-checking bench for instr_fetch_unit. Inputs are
//               driven and outputs sampled 1 time unit after each rising edge.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One fetch from IDLE: enIF for one cycle, ack after 'dly' ack-less REQ
    // cycles. Returns in DONE; reports address and request seen in REQ.
    task automatic fetch(input logic [15:0] word, input int dly,
                         output logic [7:0] addr_seen, output logic req_seen);
        bus.enIF = 1'b1;
        cyc(1);
        bus.enIF  = 1'b0;
        addr_seen = bus.imem_addr;
        req_seen  = bus.imem_req;
        cyc(dly);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        cyc(1);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
    endtask

    logic [7:0] a_seen;
    logic       r_seen;

    initial begin
        n_total        = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.enIF       = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_target  = 8'h00;
        bus.imem_rdata = 16'h0000;
        bus.imem_ack   = 1'b0;
        cyc(2);

        // ---------------- reset state ----------------
        chk("rst_pc",        bus.pc,         8'h00);
        chk("rst_addr",      bus.imem_addr,  8'h00);
        chk("rst_req",       bus.imem_req,   1'b0);
        chk("rst_opcode",    bus.opCode,     4'h0);
        chk("rst_ir_valid",  bus.ir_valid,   1'b0);
        chk("rst_done",      bus.fetch_done, 1'b0);
        chk("rst_err",       bus.fetch_err,  1'b0);
        chk("rst_overrun",   bus.overrun,    1'b0);
        reset = 1'b0;
        cyc(1);

        // ---------------- single fetch, 1-cycle ack ----------------
        fetch(16'h5A4C, 0, a_seen, r_seen);
        chk("c1_req",     r_seen,         1'b1);
        chk("c1_addr",    a_seen,         8'h00);
        chk("c1_done",    bus.fetch_done, 1'b1);
        chk("c1_opcode",  bus.opCode,     4'b0101);
        chk("c1_rd",      bus.rd,         3'd5);
        chk("c1_rs",      bus.rs,         3'd1);
        chk("c1_rt",      bus.rt,         3'd1);
        chk("c1_imm6",    bus.imm6,       6'h0C);
        chk("c1_pc",      bus.pc,         8'h01);
        chk("c1_irv",     bus.ir_valid,   1'b1);
        chk("c1_req_done",bus.imem_req,   1'b0);
        cyc(1);
        chk("c1_done_off",bus.fetch_done, 1'b0);

        // ---------------- back-to-back fetches, ack delayed 3 ----------------
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        fetch(16'h0123, 3, a_seen, r_seen);
        chk("c2_addr0",   a_seen,         8'h00);
        chk("c2_op0",     bus.opCode,     4'b0000);
        chk("c2_done0",   bus.fetch_done, 1'b1);
        cyc(1);
        fetch(16'h1456, 3, a_seen, r_seen);
        chk("c2_addr1",   a_seen,         8'h01);
        chk("c2_op1",     bus.opCode,     4'b0001);
        cyc(1);
        fetch(16'h2789, 3, a_seen, r_seen);
        chk("c2_addr2",   a_seen,         8'h02);
        chk("c2_op2",     bus.opCode,     4'b0010);
        chk("c2_pc",      bus.pc,         8'h03);
        cyc(1);

        // ---------------- timeout: 15 ack-less REQ cycles ----------------
        bus.enIF = 1'b1;
        cyc(1);
        bus.enIF = 1'b0;
        cyc(14);
        chk("c3_req_14",  bus.imem_req,   1'b1);
        chk("c3_err_14",  bus.fetch_err,  1'b0);
        cyc(1);
        chk("c3_req_off", bus.imem_req,   1'b0);
        chk("c3_err",     bus.fetch_err,  1'b1);
        chk("c3_done",    bus.fetch_done, 1'b0);
        chk("c3_pc",      bus.pc,         8'h03);
        chk("c3_op_kept", bus.opCode,     4'b0010);
        cyc(1);
        chk("c3_idle",    bus.imem_req,   1'b0);
        fetch(16'h3000, 0, a_seen, r_seen);
        chk("c3_addr",    a_seen,         8'h03);
        chk("c3_op_new",  bus.opCode,     4'b0011);
        chk("c3_pc_new",  bus.pc,         8'h04);
        chk("c3_err_kept",bus.fetch_err,  1'b1);
        cyc(1);

        // ---------------- pc_load together with ack ----------------
        bus.enIF = 1'b1;
        cyc(1);
        bus.enIF       = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h4111;
        bus.pc_load    = 1'b1;
        bus.pc_target  = 8'h40;
        cyc(1);
        bus.imem_ack   = 1'b0;
        bus.pc_load    = 1'b0;
        chk("c4_op",      bus.opCode,     4'b0100);
        chk("c4_pc",      bus.pc,         8'h40);
        chk("c4_done",    bus.fetch_done, 1'b1);
        cyc(1);
        fetch(16'h5000, 1, a_seen, r_seen);
        chk("c4_next_addr", a_seen,       8'h40);
        chk("c4_next_pc", bus.pc,         8'h41);
        cyc(1);

        // ------- redirect during REQ to 0xFF, then fetch wraps PC -------
        bus.enIF = 1'b1;
        cyc(1);
        bus.enIF      = 1'b0;
        bus.pc_load   = 1'b1;
        bus.pc_target = 8'hFF;
        cyc(1);
        bus.pc_load   = 1'b0;
        chk("c5_pc_ff",   bus.pc,         8'hFF);
        chk("c5_addr_hold", bus.imem_addr, 8'h41);
        chk("c5_req_hold",bus.imem_req,   1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h6000;
        cyc(1);
        bus.imem_ack   = 1'b0;
        chk("c5_pc_wrap", bus.pc,         8'h00);
        chk("c5_op",      bus.opCode,     4'b0110);
        cyc(1);

        // ---------------- enIF while busy -> overrun ----------------
        chk("c6_ovr_pre", bus.overrun,    1'b0);
        bus.enIF = 1'b1;
        cyc(2);
        bus.enIF = 1'b0;
        chk("c6_ovr",     bus.overrun,    1'b1);
        chk("c6_req",     bus.imem_req,   1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h7000;
        cyc(1);
        bus.imem_ack   = 1'b0;
        chk("c6_done",    bus.fetch_done, 1'b1);
        chk("c6_pc",      bus.pc,         8'h01);
        cyc(1);
        chk("c6_no_queue0", bus.imem_req, 1'b0);
        cyc(2);
        chk("c6_no_queue2", bus.imem_req, 1'b0);
        chk("c6_ovr_kept",bus.overrun,    1'b1);

        // ---------------- ack outside REQ is ignored ----------------
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hF0F0;
        cyc(1);
        bus.imem_ack   = 1'b0;
        chk("c7_ack_idle_op", bus.opCode, 4'b0111);
        chk("c7_ack_idle_pc", bus.pc,     8'h01);

        // ---------------- reset in REQ with ack high ----------------
        bus.enIF = 1'b1;
        cyc(1);
        bus.enIF       = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hABCD;
        reset          = 1'b1;
        cyc(1);
        reset          = 1'b0;
        bus.imem_ack   = 1'b0;
        chk("c8_op",      bus.opCode,     4'h0);
        chk("c8_imm6",    bus.imm6,       6'h00);
        chk("c8_irv",     bus.ir_valid,   1'b0);
        chk("c8_done",    bus.fetch_done, 1'b0);
        chk("c8_req",     bus.imem_req,   1'b0);
        chk("c8_pc",      bus.pc,         8'h00);
        chk("c8_ovr",     bus.overrun,    1'b0);
        chk("c8_err",     bus.fetch_err,  1'b0);
        cyc(1);
        chk("c8_done_after", bus.fetch_done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
